rv32_mem_responder: RTL and testbench
=====================================

// Module: rv32_mem_responder
// PURPOSE
//   Responder end of the core's instruction and data memory buses: one single-ported,
//   byte-writable word RAM serving both buses with a fixed, parameterised latency.
//   Drives instr_ready/data_ready back to the core and is instantiated beside rv32 in
//   SoC tops and benches. Data bus has priority; granted accesses are never pre-empted.
// PARAMETERS
//   ADDR_BITS    10  log2 of RAM depth in 32-bit words (default 4 KiB)
//   WAIT_STATES  0   extra cycles between grant and ready (0..15)
// PORTS
//   clk                   in   1   clock; all state updates on rising edge
//   reset                 in   1   synchronous, active-high reset
//   instr_address_in      in   32  fetch byte address; bits [1:0] ignored
//   instr_read_in         in   1   fetch request; held until instr_ready_out
//   instr_read_value_out  out  32  fetch data, valid when instr_ready_out=1
//   instr_ready_out       out  1   one-cycle completion pulse for fetch
//   data_address_in       in   32  load/store byte address; bits [1:0] ignored
//   data_read_in          in   1   load request; held until data_ready_out
//   data_write_in         in   1   store request; held until data_ready_out
//   data_write_mask_in    in   4   byte enables; bit n writes byte lane n
//   data_write_value_in   in   32  store data, lane-aligned
//   data_read_value_out   out  32  load data (full word), valid when data_ready_out=1
//   data_ready_out        out  1   one-cycle completion pulse for data
// BEHAVIOUR
//   - Reset: state IDLE, both ready outputs 0, both read_value outputs 32'h0,
//     wait counter 0. RAM contents untouched by reset.
//   - Word index = address[ADDR_BITS+1:2]; upper address bits ignored (wrap).
//   - FSM IDLE -> WAIT -> RESP -> IDLE:
//     IDLE: if data_read_in|data_write_in, grant DATA; else if instr_read_in, grant
//       INSTR; latch port, index, mask, write value. Go WAIT if WAIT_STATES>0, else RESP.
//     WAIT: count down WAIT_STATES cycles, then RESP.
//     RESP: granted ready=1 for exactly this cycle, read value valid; -> IDLE.
//   - Latency: request sampled at edge N -> ready high in cycle N+1+WAIT_STATES.
//     Back-to-back throughput: one access per WAIT_STATES+2 cycles.
//   - IDLE never sees the just-completed request (still high during RESP), so the
//     same request is not re-granted.
//   - Read: RAM read registered at the edge entering RESP; read_value_out then holds
//     until the next response on that port.
//   - Write: bytes with mask=1 committed on the edge entering RESP; mask 4'b0000
//     still completes with ready but writes nothing.
//   - read and write both high: read returns pre-write data (read-before-write); the
//     write commits.
//   - Request drop/change after grant (protocol violation): latched transaction still
//     completes and ready still pulses. No error signalling.
//   - Simultaneous instr and data requests in IDLE: data granted; instr waits, no
//     loss. Instr starvation while data is back-to-back is permitted.
//   - Reset mid-transaction: abort to IDLE, no ready pulse. A write whose commit edge
//     coincides with reset is not committed.
//   - Ready outputs never both 1; never 1 outside RESP.
// STRUCTURE
//   - Shared package rv32_mem_pkg: state enum {IDLE, WAIT, RESP}, grant enum
//     {GRANT_INSTR, GRANT_DATA}, bus width constants (XLEN=32, MASK_BITS=4).
//   - Sub-module rv32_ram_bytewise: single-port, 2**ADDR_BITS x 32 RAM, 4 byte write
//     enables, registered read, read-before-write. FSM, arbiter, counter in top.
// TESTING
//   1. After reset: both ready 0, both read values 0; no request for 10 cycles ->
//      ready stays 0.
//   2. WAIT_STATES=0: store 0xDEADBEEF @0x10 mask 4'hF, then load @0x10 ->
//      data_ready 1 cycle after each grant; load returns 0xDEADBEEF.
//   3. Byte mask: store 0x000000AA mask 4'b0001 @0x10, load @0x10 -> 0xDEADBEAA.
//      Mask 4'b0000 -> ready pulses, word unchanged.
//   4. Contention: instr and data requests in the same cycle -> data_ready first,
//      then instr_ready WAIT_STATES+2 cycles later; no cycle has both ready high.
//   5. WAIT_STATES=3: fetch @0x0 sampled at edge N -> instr_ready only in cycle N+4.
//      Address 0x1000+0x10 aliases 0x10 when ADDR_BITS=10.
//   6. Reset in WAIT of a store -> no ready pulse, target word unchanged, FSM IDLE;
//      the next request completes normally.

Source files
------------

// File: rtl/rv32_mem_pkg.sv
// Shared types for the rv32 memory responder.
// Covers the FSM state, the bus grant and the bus widths.
package rv32_mem_pkg;

   localparam int XLEN      = 32;
   localparam int MASK_BITS = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef enum logic {
      GRANT_INSTR = 1'b0,
      GRANT_DATA  = 1'b1
   } grant_t;

endpackage

// File: rtl/rv32_ram_bytewise.sv
// Single-port word RAM with per-byte write enables.
// The read is registered, and a read in the same cycle as a write sees the old word.
module rv32_ram_bytewise
   import rv32_mem_pkg::*;
#(
   parameter int ADDR_BITS = 10
) (
   input  logic                 clk,
   input  logic                 en,
   input  logic [MASK_BITS-1:0] we,
   input  logic [ADDR_BITS-1:0] addr,
   input  logic [XLEN-1:0]      wdata,
   output logic [XLEN-1:0]      rdata
);

   logic [XLEN-1:0] mem [2**ADDR_BITS];

   always_ff @(posedge clk) begin
      if (en) begin
         rdata <= mem[addr];
         for (int b = 0; b < MASK_BITS; b++) begin
            if (we[b]) begin
               mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/rv32_mem_responder.sv
// Fixed-latency responder for the core's instruction and data buses.
// Both buses share one RAM, and the data bus wins when both request.
module rv32_mem_responder
   import rv32_mem_pkg::*;
#(
   parameter int ADDR_BITS   = 10,
   parameter int WAIT_STATES = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [XLEN-1:0]      instr_address_in,
   input  logic                 instr_read_in,
   output logic [XLEN-1:0]      instr_read_value_out,
   output logic                 instr_ready_out,
   input  logic [XLEN-1:0]      data_address_in,
   input  logic                 data_read_in,
   input  logic                 data_write_in,
   input  logic [MASK_BITS-1:0] data_write_mask_in,
   input  logic [XLEN-1:0]      data_write_value_in,
   output logic [XLEN-1:0]      data_read_value_out,
   output logic                 data_ready_out
);

   localparam logic [3:0] WAIT_LOAD =
      4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

   state_t                 state_q;
   grant_t                 grant_q;
   logic [ADDR_BITS-1:0]   idx_q;
   logic [MASK_BITS-1:0]   mask_q;
   logic [XLEN-1:0]        wval_q;
   logic [3:0]             cnt_q;
   logic [XLEN-1:0]        ihold_q;
   logic [XLEN-1:0]        dhold_q;

   logic                   data_req;
   logic                   any_req;
   grant_t                 new_grant;
   logic [ADDR_BITS-1:0]   new_idx;
   logic [MASK_BITS-1:0]   new_mask;
   logic                   go_resp;
   logic [ADDR_BITS-1:0]   ram_idx;
   logic [MASK_BITS-1:0]   ram_we;
   logic [XLEN-1:0]        ram_wdata;
   logic [XLEN-1:0]        ram_rdata;
   logic                   unused_addr;

   assign unused_addr = ^{instr_address_in[XLEN-1:ADDR_BITS+2],
                          instr_address_in[1:0],
                          data_address_in[XLEN-1:ADDR_BITS+2],
                          data_address_in[1:0]};

   assign data_req  = data_read_in | data_write_in;
   assign any_req   = data_req | instr_read_in;
   assign new_grant = data_req ? GRANT_DATA : GRANT_INSTR;
   assign new_idx   = data_req ? data_address_in[ADDR_BITS+1:2]
                               : instr_address_in[ADDR_BITS+1:2];
   assign new_mask  = data_write_in ? data_write_mask_in : '0;

   // With no wait states the RAM is accessed on the grant edge itself,
   // so it must see the live request rather than the latched copy.
   always_comb begin
      go_resp   = 1'b0;
      ram_idx   = idx_q;
      ram_we    = mask_q;
      ram_wdata = wval_q;
      if (state_q == IDLE) begin
         go_resp   = any_req && (WAIT_STATES == 0);
         ram_idx   = new_idx;
         ram_we    = new_mask;
         ram_wdata = data_write_value_in;
      end else if (state_q == WAIT) begin
         go_resp   = (cnt_q == 4'd0);
      end
      go_resp = go_resp & ~reset;
      if (!go_resp) begin
         ram_we = '0;
      end
   end

   rv32_ram_bytewise #(
      .ADDR_BITS (ADDR_BITS)
   ) u_ram (
      .clk   (clk),
      .en    (go_resp),
      .we    (ram_we),
      .addr  (ram_idx),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= GRANT_INSTR;
         idx_q   <= '0;
         mask_q  <= '0;
         wval_q  <= '0;
         cnt_q   <= 4'd0;
         ihold_q <= '0;
         dhold_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (any_req) begin
                  grant_q <= new_grant;
                  idx_q   <= new_idx;
                  mask_q  <= new_mask;
                  wval_q  <= data_write_value_in;
                  cnt_q   <= WAIT_LOAD;
                  state_q <= (WAIT_STATES == 0) ? RESP : WAIT;
               end
            end
            WAIT: begin
               if (cnt_q == 4'd0) begin
                  state_q <= RESP;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            RESP: begin
               state_q <= IDLE;
               if (grant_q == GRANT_DATA) begin
                  dhold_q <= ram_rdata;
               end else begin
                  ihold_q <= ram_rdata;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign instr_ready_out = (state_q == RESP) && (grant_q == GRANT_INSTR);
   assign data_ready_out  = (state_q == RESP) && (grant_q == GRANT_DATA);

   assign instr_read_value_out = instr_ready_out ? ram_rdata : ihold_q;
   assign data_read_value_out  = data_ready_out ? ram_rdata : dhold_q;

endmodule

// File: tb/tb_rv32_mem_responder.sv
// Scoreboard bench for rv32_mem_responder, with one instance at 0 and one at 3 wait states.
// A byte-level memory model predicts every response and its arrival cycle.
module tb_rv32_mem_responder;

   typedef struct {
      bit          port;
      logic [31:0] data;
      logic [3:0]  bv;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst    [2];
   logic [31:0] i_addr [2];
   logic        i_rd   [2];
   logic [31:0] i_rval [2];
   logic        i_rdy  [2];
   logic [31:0] d_addr [2];
   logic        d_rd   [2];
   logic        d_wr   [2];
   logic [3:0]  d_mask [2];
   logic [31:0] d_wv   [2];
   logic [31:0] d_rval [2];
   logic        d_rdy  [2];

   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   exp_t sb [2][$];

   logic [31:0] mem_m [2][1024];
   logic [3:0]  vld_m [2][1024];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      rv32_mem_responder #(
         .ADDR_BITS   (10),
         .WAIT_STATES (g == 0 ? 0 : 3)
      ) u_dut (
         .clk                  (clk),
         .reset                (rst[g]),
         .instr_address_in     (i_addr[g]),
         .instr_read_in        (i_rd[g]),
         .instr_read_value_out (i_rval[g]),
         .instr_ready_out      (i_rdy[g]),
         .data_address_in      (d_addr[g]),
         .data_read_in         (d_rd[g]),
         .data_write_in        (d_wr[g]),
         .data_write_mask_in   (d_mask[g]),
         .data_write_value_in  (d_wv[g]),
         .data_read_value_out  (d_rval[g]),
         .data_ready_out       (d_rdy[g])
      );
   end

   function automatic int ws(input int i);
      return (i == 0) ? 0 : 3;
   endfunction

   function automatic logic [31:0] bmask(input logic [3:0] bv);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) r[8*b +: 8] = {8{bv[b]}};
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %h want %h", nm, got, want);
      end
   endtask

   // Monitor: pops the scoreboard on every ready pulse.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         exp_t e;
         logic [31:0] got;
         logic [31:0] mk;
         if (i_rdy[i] && d_rdy[i]) begin
            tests++;
            fails++;
            $display("FAIL both_ready inst%0d: got 1/1 want one", i);
         end
         if (i_rdy[i] || d_rdy[i]) begin
            tests++;
            if (sb[i].size() == 0) begin
               fails++;
               $display("FAIL unexpected_ready inst%0d: got %0d%0d want 00",
                        i, i_rdy[i], d_rdy[i]);
            end else begin
               e   = sb[i].pop_front();
               got = d_rdy[i] ? d_rval[i] : i_rval[i];
               mk  = bmask(e.bv);
               if (d_rdy[i] != e.port) begin
                  fails++;
                  $display("FAIL port inst%0d: got %0d want %0d",
                           i, d_rdy[i], e.port);
               end else if ((got & mk) !== (e.data & mk)) begin
                  fails++;
                  $display("FAIL rdata inst%0d: got %h want %h mask %h",
                           i, got, e.data, mk);
               end else if (cyc != e.cyc) begin
                  fails++;
                  $display("FAIL latency inst%0d: got cycle %0d want %0d",
                           i, cyc, e.cyc);
               end
            end
         end
      end
   end

   task automatic predict(input int i, input bit dport, input bit rd,
                          input bit wr, input logic [31:0] a,
                          input logic [3:0] m, input logic [31:0] wv,
                          input int lat, output exp_t e);
      int idx;
      idx    = int'(a[11:2]);
      e.port = dport;
      e.data = mem_m[i][idx];
      e.bv   = (!dport || rd) ? vld_m[i][idx] : 4'h0;
      e.cyc  = cyc + 1 + lat;
      if (wr) begin
         for (int b = 0; b < 4; b++) begin
            if (m[b]) begin
               mem_m[i][idx][8*b +: 8] = wv[8*b +: 8];
               vld_m[i][idx][b] = 1'b1;
            end
         end
      end
   endtask

   task automatic set_req(input int i, input bit dport, input bit rd,
                          input bit wr, input logic [31:0] a,
                          input logic [3:0] m, input logic [31:0] wv);
      if (dport) begin
         d_rd[i] = rd; d_wr[i] = wr; d_addr[i] = a;
         d_mask[i] = m; d_wv[i] = wv;
      end else begin
         i_rd[i] = 1'b1; i_addr[i] = a;
      end
   endtask

   task automatic clr_req(input int i, input bit dport);
      if (dport) begin
         d_rd[i] = 1'b0; d_wr[i] = 1'b0;
         d_wv[i] = $urandom; d_mask[i] = 4'($urandom);
      end else begin
         i_rd[i] = 1'b0;
      end
   endtask

   task automatic access(input int i, input bit dport, input bit rd,
                         input bit wr, input logic [31:0] a,
                         input logic [3:0] m, input logic [31:0] wv);
      exp_t e;
      bit   seen;
      @(negedge clk);
      set_req(i, dport, rd, wr, a, m, wv);
      predict(i, dport, rd, wr, a, m, wv, ws(i), e);
      sb[i].push_back(e);
      seen = 1'b0;
      for (int n = 0; n < 40 && !seen; n++) begin
         @(negedge clk);
         seen = dport ? d_rdy[i] : i_rdy[i];
      end
      if (!seen) begin
         tests++;
         fails++;
         $display("FAIL timeout inst%0d: got no ready want ready", i);
         void'(sb[i].pop_back());
      end
      clr_req(i, dport);
   endtask

   task automatic contend(input int i, input bit wr,
                          input logic [31:0] da, input logic [31:0] ia,
                          input logic [3:0] m, input logic [31:0] wv);
      exp_t ed, ei;
      bit   dd, id;
      @(negedge clk);
      set_req(i, 1'b1, !wr, wr, da, m, wv);
      set_req(i, 1'b0, 1'b1, 1'b0, ia, 4'h0, 32'h0);
      predict(i, 1'b1, !wr, wr, da, m, wv, ws(i), ed);
      predict(i, 1'b0, 1'b1, 1'b0, ia, 4'h0, 32'h0,
              2 * ws(i) + 2, ei);
      sb[i].push_back(ed);
      sb[i].push_back(ei);
      dd = 1'b0;
      id = 1'b0;
      for (int n = 0; n < 80 && !id; n++) begin
         @(negedge clk);
         if (d_rdy[i]) begin dd = 1'b1; clr_req(i, 1'b1); end
         if (i_rdy[i]) begin id = 1'b1; clr_req(i, 1'b0); end
      end
      if (!dd || !id) begin
         tests++;
         fails++;
         $display("FAIL contend_timeout inst%0d: got %0d%0d want 11",
                  i, dd, id);
         sb[i].delete();
         clr_req(i, 1'b1);
         clr_req(i, 1'b0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen_rdy;
      for (int i = 0; i < 2; i++) begin
         for (int w = 0; w < 1024; w++) begin
            vld_m[i][w] = 4'h0;
            mem_m[i][w] = 32'h0;
         end
         rst[i] = 1'b1;
         i_rd[i] = 1'b0; d_rd[i] = 1'b0; d_wr[i] = 1'b0;
         i_addr[i] = '0; d_addr[i] = '0; d_mask[i] = '0; d_wv[i] = '0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rst_irdy%0d", i), 32'(i_rdy[i]), 32'h0);
         chk($sformatf("rst_drdy%0d", i), 32'(d_rdy[i]), 32'h0);
         chk($sformatf("rst_ival%0d", i), i_rval[i], 32'h0);
         chk($sformatf("rst_dval%0d", i), d_rval[i], 32'h0);
         rst[i] = 1'b0;
      end
      seen_rdy = 1'b0;
      repeat (10) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++)
            if (i_rdy[i] || d_rdy[i]) seen_rdy = 1'b1;
      end
      chk("idle_no_ready", 32'(seen_rdy), 32'h0);

      // Full store, load, byte store and empty-mask store on the zero-wait instance.
      access(0, 1, 0, 1, 32'h10, 4'hF, 32'hDEADBEEF);
      access(0, 1, 1, 0, 32'h10, 4'h0, 32'h0);
      @(negedge clk);
      chk("load_hold", d_rval[0], 32'hDEADBEEF);
      access(0, 1, 0, 1, 32'h10, 4'b0001, 32'h000000AA);
      access(0, 1, 1, 0, 32'h10, 4'h0, 32'h0);
      chk("byte_store", d_rval[0], 32'hDEADBEAA);
      access(0, 1, 0, 1, 32'h10, 4'b0000, 32'h12345678);
      access(0, 1, 1, 0, 32'h10, 4'h0, 32'h0);
      chk("mask_zero", d_rval[0], 32'hDEADBEAA);
      access(0, 1, 1, 1, 32'h10, 4'hF, 32'h0BADF00D);
      chk("read_before_write", d_rval[0], 32'hDEADBEAA);
      contend(0, 1'b1, 32'h30, 32'h30, 4'hF, 32'hA5A5_0001);
      chk("contend_fetch", i_rval[0], 32'hA5A5_0001);

      // A store whose commit edge meets reset is dropped.
      access(0, 1, 0, 1, 32'h24, 4'hF, 32'h11111111);
      @(negedge clk);
      set_req(0, 1, 0, 1, 32'h24, 4'hF, 32'h99999999);
      rst[0] = 1'b1;
      @(negedge clk);
      rst[0] = 1'b0;
      clr_req(0, 1'b1);
      access(0, 1, 1, 0, 32'h24, 4'h0, 32'h0);
      chk("reset_commit", d_rval[0], 32'h11111111);

      // Three-wait instance: latency, aliasing and reset during WAIT.
      access(1, 1, 0, 1, 32'h0, 4'hF, 32'h00C0FFEE);
      access(1, 0, 1, 0, 32'h0, 4'h0, 32'h0);
      chk("fetch_ws3", i_rval[1], 32'h00C0FFEE);
      access(1, 1, 0, 1, 32'h1010, 4'hF, 32'h55AA55AA);
      access(1, 1, 1, 0, 32'h10, 4'h0, 32'h0);
      chk("alias", d_rval[1], 32'h55AA55AA);
      contend(1, 1'b0, 32'h10, 32'h0, 4'h0, 32'h0);
      access(1, 1, 0, 1, 32'h20, 4'hF, 32'hCAFEF00D);
      @(negedge clk);
      set_req(1, 1, 0, 1, 32'h20, 4'hF, 32'hFFFFFFFF);
      @(negedge clk);
      @(negedge clk);
      rst[1] = 1'b1;
      clr_req(1, 1'b1);
      @(negedge clk);
      rst[1] = 1'b0;
      chk("rst_wait_rdy", 32'(d_rdy[1]), 32'h0);
      chk("rst_wait_dval", d_rval[1], 32'h0);
      access(1, 1, 1, 0, 32'h20, 4'h0, 32'h0);
      chk("rst_wait_word", d_rval[1], 32'hCAFEF00D);

      // Random traffic on both instances.
      for (int i = 0; i < 2; i++) begin
         for (int n = 0; n < 60; n++) begin
            int          k;
            logic [31:0] a, a2, wv;
            logic [3:0]  m;
            k  = $urandom_range(0, 4);
            a  = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 7)) << 2)
                 | 32'($urandom_range(0, 3));
            a2 = 32'($urandom_range(0, 7)) << 2;
            wv = $urandom;
            m  = 4'($urandom_range(0, 15));
            unique case (k)
               0: access(i, 0, 1, 0, a, 4'h0, 32'h0);
               1: access(i, 1, 1, 0, a, 4'h0, 32'h0);
               2: access(i, 1, 0, 1, a, m, wv);
               3: access(i, 1, 1, 1, a, m, wv);
               default: contend(i, wv[0], a, a2, m, wv);
            endcase
            if ($urandom_range(0, 1) == 1) @(negedge clk);
         end
      end

      repeat (5) @(negedge clk);
      for (int i = 0; i < 2; i++)
         chk($sformatf("sb_empty%0d", i), 32'(sb[i].size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
